param_shift: RTL and testbench



---
 rtl/param_shift.sv | 130 +++++++++++++
 tb/tb_param_shift.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/param_shift.sv
`default_nettype none
// ============================================================================
// Module   : param_shift
// Brief    : Parametrised universal shift register. Supports shift left/right,
//            rotate left/right and parallel load. A shift-count framer captures
//            the storage word after every WIDTH shifts, so the block can act
//            as a serial-to-parallel deserialiser.
// Revision : 1.0 - initial release
// ============================================================================
module param_shift #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             ClkIn,
  input  logic             ClrNIn,
  input  logic             ShiftEna,
  input  logic [2:0]       Mode,
  input  logic             DInL,
  input  logic             DInR,
  input  logic [WIDTH-1:0] PIn,
  output logic             SOutL,
  output logic             SOutR,
  output logic [WIDTH-1:0] QOut_p,
  output logic             FrameDone,
  output logic [WIDTH-1:0] WordOut
);

  // Counter width follows WIDTH; it is derived here so it cannot be overridden.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_LOAD = 3'd5;

  logic [WIDTH-1:0] QReg_q, QReg_d;
  logic [CNT_W-1:0] ShCnt_q, ShCnt_d;
  logic             FrameDone_q, FrameDone_d;
  logic [WIDTH-1:0] WordOut_q, WordOut_d;

  logic             w_is_shift;
  logic [WIDTH-1:0] w_shift_val;

  // Select the new storage value for the four shift/rotate operations.
  always_comb begin
    w_is_shift  = 1'b0;
    w_shift_val = QReg_q;
    case (Mode)
      MODE_SHL: begin
        w_is_shift  = 1'b1;
        w_shift_val = {QReg_q[WIDTH-2:0], DInL};
      end
      MODE_SHR: begin
        w_is_shift  = 1'b1;
        w_shift_val = {DInR, QReg_q[WIDTH-1:1]};
      end
      MODE_ROL: begin
        w_is_shift  = 1'b1;
        w_shift_val = {QReg_q[WIDTH-2:0], QReg_q[WIDTH-1]};
      end
      MODE_ROR: begin
        w_is_shift  = 1'b1;
        w_shift_val = {QReg_q[0], QReg_q[WIDTH-1:1]};
      end
      default: begin
        w_is_shift  = 1'b0;
        w_shift_val = QReg_q;
      end
    endcase
  end

  // Next-state for storage, frame counter, frame pulse and captured word.
  always_comb begin
    QReg_d      = QReg_q;
    ShCnt_d     = ShCnt_q;
    FrameDone_d = 1'b0;
    WordOut_d   = WordOut_q;
    if (ShiftEna) begin
      if (w_is_shift) begin
        QReg_d = w_shift_val;
        if (ShCnt_q == C_CNT_LAST) begin
          // Final shift of the frame: the captured word includes this bit.
          ShCnt_d     = '0;
          FrameDone_d = 1'b1;
          WordOut_d   = w_shift_val;
        end else begin
          ShCnt_d = ShCnt_q + 1'b1;
        end
      end else if (Mode == MODE_LOAD) begin
        // A load restarts framing but leaves the last captured word alone.
        QReg_d  = PIn;
        ShCnt_d = '0;
      end else begin
        // MODE_HOLD and reserved encodings keep everything.
        QReg_d = QReg_q;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge ClkIn or negedge ClrNIn) begin
    if (!ClrNIn) begin
      QReg_q      <= RESET_VAL;
      ShCnt_q     <= '0;
      FrameDone_q <= 1'b0;
      WordOut_q   <= '0;
    end else begin
      QReg_q      <= QReg_d;
      ShCnt_q     <= ShCnt_d;
      FrameDone_q <= FrameDone_d;
      WordOut_q   <= WordOut_d;
    end
  end

  assign QOut_p    = QReg_q;
  assign SOutL     = QReg_q[WIDTH-1];
  assign SOutR     = QReg_q[0];
  assign FrameDone = FrameDone_q;
  assign WordOut   = WordOut_q;

  // MODE_HOLD is named for readability of the encoding table only.
  logic w_unused_hold;
  assign w_unused_hold = (Mode == MODE_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_param_shift.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_shift
// Brief    : Directed self-checking bench for param_shift (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_shift;

  logic       ClkIn;
  logic       ClrNIn;
  logic       ShiftEna;
  logic [2:0] Mode;
  logic       DInL;
  logic       DInR;
  logic [7:0] PIn;
  logic       SOutL;
  logic       SOutR;
  logic [7:0] QOut_p;
  logic       FrameDone;
  logic [7:0] WordOut;

  int n_tests = 0;
  int n_fail  = 0;

  param_shift #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .ClkIn    (ClkIn),
    .ClrNIn   (ClrNIn),
    .ShiftEna (ShiftEna),
    .Mode     (Mode),
    .DInL     (DInL),
    .DInR     (DInR),
    .PIn      (PIn),
    .SOutL    (SOutL),
    .SOutR    (SOutR),
    .QOut_p   (QOut_p),
    .FrameDone(FrameDone),
    .WordOut  (WordOut)
  );

  initial ClkIn = 1'b0;
  always #5 ClkIn = ~ClkIn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one operation at the next rising edge; returns 1 ns after it.
  task automatic op(input logic ena, input logic [2:0] m, input logic dl,
                    input logic dr, input logic [7:0] pin);
    ShiftEna = ena;
    Mode     = m;
    DInL     = dl;
    DInR     = dr;
    PIn      = pin;
    @(posedge ClkIn);
    #1;
  endtask

  logic [7:0] seq;
  logic [7:0] exp_q [8];

  initial begin
    ClrNIn = 1'b0; ShiftEna = 1'b0; Mode = 3'd0;
    DInL = 1'b0; DInR = 1'b0; PIn = 8'h00;
    #12 ClrNIn = 1'b1;

    // ---- 1. asynchronous reset from 8'hFF ----
    op(1, 3'd5, 0, 0, 8'hFF);
    chk("load_ff", QOut_p, 8'hFF);
    #2 ClrNIn = 1'b0;
    #1;
    chk("rst_q", QOut_p, 8'h00);
    chk("rst_fd", FrameDone, 1'b0);
    chk("rst_word", WordOut, 8'h00);
    op(1, 3'd5, 1, 1, 8'h55);
    chk("rst_held_q", QOut_p, 8'h00);
    chk("rst_held_fd", FrameDone, 1'b0);
    #2 ClrNIn = 1'b1;

    // ---- 2. serial deserialise 1,1,1,0,0,1,0,1 ----
    seq = 8'b11100101;
    exp_q = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C, 8'h39, 8'h72, 8'hE5};
    for (int i = 0; i < 8; i++) begin
      op(1, 3'd1, seq[7-i], 0, 8'h00);
      chk("deser_q", QOut_p, exp_q[i]);
      chk("deser_fd", FrameDone, (i == 7) ? 1'b1 : 1'b0);
    end
    chk("deser_word", WordOut, 8'hE5);
    op(1, 3'd1, 0, 0, 8'h00);
    chk("deser_next_fd", FrameDone, 1'b0);
    chk("deser_next_q", QOut_p, 8'hCA);

    // ---- 3. load and rotate ----
    op(1, 3'd5, 0, 0, 8'hA5);
    chk("load_a5", QOut_p, 8'hA5);
    chk("load_fd", FrameDone, 1'b0);
    op(1, 3'd4, 0, 0, 8'h00);
    chk("ror_q", QOut_p, 8'hD2);
    chk("ror_soutr", SOutR, 1'b0);
    // Seven left rotates of D2 equal one right rotate: 8'h69.
    exp_q = '{8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'h00};
    for (int i = 0; i < 7; i++) begin
      op(1, 3'd3, 0, 0, 8'h00);
      chk("rol_q", QOut_p, exp_q[i]);
      chk("rol_fd", FrameDone, (i == 6) ? 1'b1 : 1'b0);
    end
    chk("rol_word", WordOut, 8'h69);

    // ---- 4. shift right with DInR=1 ----
    op(1, 3'd5, 0, 0, 8'h00);
    exp_q = '{8'h80, 8'hC0, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      op(1, 3'd2, 0, 1, 8'h00);
      chk("shr_q", QOut_p, exp_q[i]);
      chk("shr_fd", FrameDone, 1'b0);
    end
    chk("shr_soutl", SOutL, 1'b1);
    chk("shr_soutr", SOutR, 1'b0);

    // ---- 5. enable gap, then the same with reserved mode 6 ----
    op(1, 3'd5, 0, 0, 8'h00);
    for (int pass = 0; pass < 2; pass++) begin
      exp_q = '{8'h01, 8'h03, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      if (pass == 1) exp_q = '{8'hC1, 8'h83, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 3; i++) begin
        op(1, 3'd1, 1, 0, 8'h00);
        chk("gap_pre_q", QOut_p, exp_q[i]);
        chk("gap_pre_fd", FrameDone, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
        if (pass == 0) op(0, 3'd5, 1, 1, 8'hAA);
        else           op(1, 3'd6, 1, 1, 8'hAA);
        chk("gap_hold_q", QOut_p, 8'h07);
        chk("gap_hold_fd", FrameDone, 1'b0);
      end
      exp_q = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 5; i++) begin
        op(1, 3'd1, 0, 0, 8'h00);
        chk("gap_post_q", QOut_p, exp_q[i]);
        chk("gap_post_fd", FrameDone, (i == 4) ? 1'b1 : 1'b0);
      end
      chk("gap_word", WordOut, 8'hE0);
    end

    // ---- 6a. mid-frame asynchronous reset ----
    exp_q = '{8'hC1, 8'h83, 8'h07, 8'h0F, 8'h1F, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      op(1, 3'd1, 1, 0, 8'h00);
      chk("mid_pre_q", QOut_p, exp_q[i]);
    end
    #2 ClrNIn = 1'b0;
    #1;
    chk("mid_rst_q", QOut_p, 8'h00);
    chk("mid_rst_word", WordOut, 8'h00);
    #2 ClrNIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op(1, 3'd1, 1, 0, 8'h00);
      chk("mid_post_fd", FrameDone, (i == 7) ? 1'b1 : 1'b0);
    end
    chk("mid_post_q", QOut_p, 8'hFF);
    chk("mid_post_word", WordOut, 8'hFF);

    // ---- 6b. load after 6 shifts restarts the frame ----
    for (int i = 0; i < 6; i++) begin
      op(1, 3'd1, 0, 0, 8'h00);
      chk("ld_pre_fd", FrameDone, 1'b0);
    end
    chk("ld_pre_q", QOut_p, 8'hC0);
    op(1, 3'd5, 0, 0, 8'h3C);
    chk("ld_q", QOut_p, 8'h3C);
    chk("ld_word", WordOut, 8'hFF);
    chk("ld_fd", FrameDone, 1'b0);
    exp_q = '{8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      op(1, 3'd1, 0, 0, 8'h00);
      chk("ld_post_q", QOut_p, exp_q[i]);
      chk("ld_post_fd", FrameDone, (i == 7) ? 1'b1 : 1'b0);
    end
    chk("ld_post_word", WordOut, 8'h00);
    op(1, 3'd0, 0, 0, 8'h00);
    chk("hold_fd", FrameDone, 1'b0);
    chk("hold_word", WordOut, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
